// File: rtl/fifo_sync.sv
// Single-clock FIFO: DEPTH = 2**ADDR_WIDTH words of DATA_WIDTH bits.
// Illegal pushes (full) and pops (empty) are silently dropped.
//
// Ports:
//   clk      in  single clock, all state on rising edge
//   rst_n    in  async active-low reset
//   wr_en    in  push request
//   rd_en    in  pop request
//   data_in  in  word to push
//   data_out out registered word of the last accepted pop
//   full     out registered, DEPTH words stored
//   empty    out registered, no words stored
module fifo_sync #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_full;
  logic                  r_empty;

  logic                  w_write_ok;
  logic                  w_read_ok;
  logic [ADDR_WIDTH:0]   w_wr_next;
  logic [ADDR_WIDTH:0]   w_rd_next;
  logic                  w_full_next;
  logic                  w_empty_next;

  // Accept decisions use the registered (pre-edge) flags.
  assign w_write_ok = wr_en & ~r_full;
  assign w_read_ok  = rd_en & ~r_empty;

  assign w_wr_next = w_write_ok ? r_wr_ptr + PTR_ONE
                                : r_wr_ptr;
  assign w_rd_next = w_read_ok ? r_rd_ptr + PTR_ONE
                               : r_rd_ptr;

  // Wrap bit distinguishes full from empty when
  // the low address bits coincide.
  assign w_empty_next = (w_wr_next == w_rd_next);
  assign w_full_next  =
    (w_wr_next[ADDR_WIDTH] != w_rd_next[ADDR_WIDTH]) &&
    (w_wr_next[ADDR_WIDTH-1:0] ==
     w_rd_next[ADDR_WIDTH-1:0]);

  // Storage is not reset; stale words are unreachable
  // once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (w_write_ok)
      r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_data_out <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_next;
      r_rd_ptr <= w_rd_next;
      r_full   <= w_full_next;
      r_empty  <= w_empty_next;
      if (w_read_ok)
        r_data_out <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
    end
  end

  assign data_out = r_data_out;
  assign full     = r_full;
  assign empty    = r_empty;

endmodule

// File: tb/tb_fifo_sync.sv
// Scoreboard bench for fifo_sync.
// Queue model tracks contents, pops and flags.
module tb_fifo_sync;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  fifo_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .data_in(data_in),
    .data_out(data_out),
    .full(full),
    .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  logic [7:0] last_dout;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic r,
                     input logic [7:0] d);
    bit wok;
    bit rok;
    logic [7:0] exp;
    wok = w && (q.size() < 16);
    rok = r && (q.size() > 0);
    exp = last_dout;
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    if (rok) exp = q.pop_front();
    if (wok) q.push_back(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    if (rok) check("dout", data_out, exp);
    else check("hold", data_out, last_dout);
    last_dout = exp;
    check("full", full, q.size() == 16);
    check("empty", empty, q.size() == 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    data_in   = '0;
    last_dout = '0;
    #12;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_dout", data_out, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: async reset with 5 words held
    for (int i = 0; i < 6; i++)
      cyc(1, 0, 8'h11 + 8'(i));
    cyc(0, 1, 0);
    check("pre_rst_cnt", q.size(), 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_empty", empty, 1);
    check("arst_full", full, 0);
    check("arst_dout", data_out, 0);
    q.delete();
    last_dout = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 2: fill, overflow, drain
    for (int i = 0; i < 16; i++)
      cyc(1, 0, 8'(i));
    check("fill_full", full, 1);
    cyc(1, 0, 8'hAA);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 0);
      check("drain_ord", data_out, i);
    end
    check("drain_empty", empty, 1);

    // 3: underflow then one word
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 0);
    check("uf_dout", data_out, 8'h0F);
    cyc(1, 0, 8'h5C);
    cyc(0, 1, 0);
    check("pop_5c", data_out, 8'h5C);

    // 4: simultaneous push/pop at occupancy 4
    for (int i = 0; i < 4; i++)
      cyc(1, 0, 8'h30 + 8'(i));
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 8'h40 + 8'(i));
      check("sim_occ", q.size(), 4);
    end
    check("sim_last", data_out, 8'h45);

    // 5: both enables while full
    for (int i = 0; i < 12; i++)
      cyc(1, 0, 8'h60 + 8'(i));
    check("pre5_full", full, 1);
    cyc(1, 1, 8'hFF);
    check("f5_oldest", data_out, 8'h46);
    check("f5_notfull", full, 0);
    while (q.size() > 0)
      cyc(0, 1, 0);
    check("f5_no_ff", data_out, 8'h6B);

    // 6: random traffic with wrap-around
    for (int i = 0; i < 40; i++)
      cyc(1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)),
          8'($urandom));
    while (q.size() > 0)
      cyc(0, 1, 0);
    check("end_empty", empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
